// File: rtl/datapath_gol_step.sv
// One generation step of Conway's Game of Life on a fixed 8x8 grid.
// The step is purely combinational: all 64 cells are evaluated in parallel
// from the same snapshot. The only state is a saturating generation counter.
// Cell (r, c) lives at bit 8*r + c. Cells outside the grid count as dead.
module datapath_gol_step (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    output logic [63:0] next_grid,
    output logic        still,
    output logic        extinct,
    output logic [15:0] gen_count
);

    localparam int unsigned SIDE    = 8;
    localparam int unsigned PAD     = SIDE + 2;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Grid surrounded by a one-cell ring of dead cells, so edges need no special case.
    logic [PAD-1:0][PAD-1:0] pad;

    genvar pr, pc;
    generate
        for (pr = 0; pr < PAD; pr++) begin : g_pad_row
            for (pc = 0; pc < PAD; pc++) begin : g_pad_col
                if (pr == 0 || pr == PAD - 1 || pc == 0 || pc == PAD - 1) begin : g_border
                    assign pad[pr][pc] = 1'b0;
                end else begin : g_inner
                    assign pad[pr][pc] = grid[SIDE * (pr - 1) + (pc - 1)];
                end
            end
        end
    endgenerate

    // Per-cell neighbour count and birth/survival rule.
    genvar r, c;
    generate
        for (r = 0; r < SIDE; r++) begin : g_row
            for (c = 0; c < SIDE; c++) begin : g_col
                logic [3:0] cnt;
                logic       alive;

                assign alive = pad[r + 1][c + 1];
                assign cnt   = 4'(pad[r][c])     + 4'(pad[r][c + 1])     + 4'(pad[r][c + 2])
                             + 4'(pad[r + 1][c])                         + 4'(pad[r + 1][c + 2])
                             + 4'(pad[r + 2][c]) + 4'(pad[r + 2][c + 1]) + 4'(pad[r + 2][c + 2]);

                assign next_grid[SIDE * r + c] = (cnt == 4'd3) | (alive & (cnt == 4'd2));
            end
        end
    endgenerate

    // Whole-grid status flags.
    assign still   = (next_grid == grid);
    assign extinct = (grid == 64'd0);

    // Generation counter: clears asynchronously, saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_count <= '0;
        end else if (gen_count != CNT_MAX) begin
            gen_count <= gen_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_datapath_gol_step.sv
// Self-checking bench for datapath_gol_step: directed patterns, counter
// behaviour around reset and saturation, and random grids against a
// plain-arithmetic Life reference.
module tb_datapath_gol_step;

    logic        clk;
    logic        reset;
    logic [63:0] grid;
    logic [63:0] next_grid;
    logic        still;
    logic        extinct;
    logic [15:0] gen_count;

    int total = 0;
    int bad   = 0;

    datapath_gol_step dut (
        .clk       (clk),
        .reset     (reset),
        .grid      (grid),
        .next_grid (next_grid),
        .still     (still),
        .extinct   (extinct),
        .gen_count (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count live neighbours inside the 8x8 board and apply B3/S23.
    function automatic logic [63:0] ref_step(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt;
                logic alive;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                            if (g[6'(rr * 8 + cc)]) cnt = cnt + 1;
                        end
                    end
                end
                alive = g[6'(r * 8 + c)];
                if (alive) n[6'(r * 8 + c)] = (cnt == 2 || cnt == 3);
                else       n[6'(r * 8 + c)] = (cnt == 3);
            end
        end
        return n;
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_next;

        reset = 1'b0;
        grid  = 64'd0;
        #2;
        reset = 1'b1;
        #1;
        check16("reset_count", gen_count, 16'h0000);

        // Combinational outputs are valid while reset is held.
        check64("empty_next", next_grid, 64'd0);
        check1("empty_extinct", extinct, 1'b1);
        check1("empty_still", still, 1'b1);

        grid = 64'h000000001C000000;
        #1;
        check64("blinker_h", next_grid, 64'h0000000808080000);
        check1("blinker_h_still", still, 1'b0);
        check1("blinker_h_extinct", extinct, 1'b0);
        grid = 64'h0000000808080000;
        #1;
        check64("blinker_v", next_grid, 64'h000000001C000000);
        check1("blinker_v_still", still, 1'b0);

        grid = 64'h0000000000000303;
        #1;
        check64("block", next_grid, 64'h0000000000000303);
        check1("block_still", still, 1'b1);

        grid = 64'hFFFFFFFFFFFFFFFF;
        #1;
        check64("full", next_grid, 64'h8100000000000081);
        check1("full_still", still, 1'b0);

        grid = 64'h8000000000000000;
        #1;
        check64("lone", next_grid, 64'd0);
        check1("lone_extinct", extinct, 1'b0);

        // Counter held at zero across clock edges during reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check16("hold_in_reset", gen_count, 16'h0000);

        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check16("count_5", gen_count, 16'd5);

        // Asynchronous clear between edges.
        #2;
        reset = 1'b1;
        #1;
        check16("async_clear", gen_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check16("first_after_release", gen_count, 16'd1);

        repeat (65533) @(posedge clk);
        @(negedge clk);
        check16("count_fffe", gen_count, 16'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check16("saturate", gen_count, 16'hFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check16("stay_saturated", gen_count, 16'hFFFF);

        #2;
        reset = 1'b1;
        #1;
        check16("clear_from_sat", gen_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check16("restart_after_sat", gen_count, 16'd2);

        // Random grids with varied densities.
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       grid = a;
                1:       grid = a & b;
                2:       grid = a | b;
                default: grid = a & b & {$urandom(), $urandom()};
            endcase
            #1;
            exp_next = ref_step(grid);
            check64("rand_next", next_grid, exp_next);
            check1("rand_still", still, exp_next == grid);
            check1("rand_extinct", extinct, grid == 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
